// File: rtl/tmds_pkg.sv
// Shared TMDS constants and serializer state type.
// Control symbols and the clock-lane pattern are the standard 10-bit TMDS code words.
package tmds_pkg;

  localparam int TMDS_WIDTH = 10;

  localparam logic [TMDS_WIDTH-1:0] TMDS_CTRL_00     = 10'b1101010100;
  localparam logic [TMDS_WIDTH-1:0] TMDS_CTRL_01     = 10'b0010101011;
  localparam logic [TMDS_WIDTH-1:0] TMDS_CTRL_10     = 10'b0101010100;
  localparam logic [TMDS_WIDTH-1:0] TMDS_CTRL_11     = 10'b1010101011;
  localparam logic [TMDS_WIDTH-1:0] TMDS_CLK_PATTERN = 10'b0000011111;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } ser_state_t;

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO with occupancy count; read data is the head word (show-ahead).
// Push when full and pop when empty are ignored.
module sync_word_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // DEPTH is a power of two, so the level MSB is set only when level == DEPTH.
  assign full    = level[AW];
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/tmds_soft_serializer.sv
// Multi-lane parallel-to-serial stage in the serial clock domain: FIFO-buffered symbol words,
// shared bit counter, per-lane shift registers, idle insertion with a saturating underflow count.
module tmds_soft_serializer
  import tmds_pkg::*;
#(
  parameter int                              CHANNELS  = 4,
  parameter int                              WIDTH     = TMDS_WIDTH,
  parameter int                              DEPTH     = 4,
  parameter bit                              LSB_FIRST = 1'b1,
  parameter logic [CHANNELS*WIDTH-1:0]       IDLE_WORD = {TMDS_CLK_PATTERN, {3{TMDS_CTRL_00}}},
  parameter int                              UFLOW_W   = 16,
  localparam int                             CW        = CHANNELS * WIDTH,
  localparam int                             LW        = $clog2(DEPTH) + 1,
  localparam int                             BW        = $clog2(WIDTH)
) (
  input  logic                clk_serial,
  input  logic                rst,
  input  logic                enable,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CW-1:0]       in_data,
  output logic [CHANNELS-1:0] ser_out,
  output logic                word_strobe,
  output logic [LW-1:0]       fifo_level,
  output logic [UFLOW_W-1:0]  underflow_cnt,
  output logic                running,
  output ser_state_t          state_dbg
);

  // Handshake: a word is accepted on any edge where in_valid && in_ready; in_ready depends
  // only on the registered FIFO level, never on in_valid.

  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  ser_state_t       state;
  ser_state_t       state_nxt;
  logic [BW-1:0]    bit_cnt;
  logic             fresh;
  logic             load_due;
  logic             load;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_head;
  logic [CW-1:0]    load_word;
  logic [WIDTH-1:0] lane_word [CHANNELS];
  logic [WIDTH-1:0] shreg     [CHANNELS];

  sync_word_fifo #(
    .WIDTH (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk_serial),
    .rst     (rst),
    .push    (in_valid && in_ready),
    .wr_data (in_data),
    .pop     (load && !fifo_empty),
    .rd_data (fifo_head),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign running   = (state == RUN);
  assign state_dbg = state;
  assign load_word = fifo_empty ? IDLE_WORD : fifo_head;

  // fresh marks the first edge after entering RUN, which loads without waiting for the counter.
  assign load_due = fresh || (bit_cnt == LAST_BIT);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      STOP: if (enable) state_nxt = RUN;
      RUN: begin
        if (load_due) begin
          if (enable) load = 1'b1;
          else        state_nxt = STOP;
        end
      end
      default: state_nxt = STOP;
    endcase
  end

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) lane_word[k] = load_word[k*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk_serial or posedge rst) begin
    if (rst) begin
      state         <= STOP;
      bit_cnt       <= '0;
      fresh         <= 1'b0;
      ser_out       <= '0;
      word_strobe   <= 1'b0;
      underflow_cnt <= '0;
      for (int k = 0; k < CHANNELS; k++) shreg[k] <= '0;
    end else begin
      state       <= state_nxt;
      word_strobe <= load;
      if (load) begin
        bit_cnt <= '0;
        fresh   <= 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
          if (LSB_FIRST) begin
            ser_out[k] <= lane_word[k][0];
            shreg[k]   <= lane_word[k] >> 1;
          end else begin
            ser_out[k] <= lane_word[k][WIDTH-1];
            shreg[k]   <= lane_word[k] << 1;
          end
        end
        if (fifo_empty && (underflow_cnt != '1)) underflow_cnt <= underflow_cnt + UFLOW_W'(1);
      end else if ((state == RUN) && (state_nxt == RUN)) begin
        bit_cnt <= bit_cnt + BW'(1);
        for (int k = 0; k < CHANNELS; k++) begin
          if (LSB_FIRST) begin
            ser_out[k] <= shreg[k][0];
            shreg[k]   <= shreg[k] >> 1;
          end else begin
            ser_out[k] <= shreg[k][WIDTH-1];
            shreg[k]   <= shreg[k] << 1;
          end
        end
      end else begin
        // Idle in STOP, or the stop edge that replaces a load: line held low.
        bit_cnt <= '0;
        ser_out <= '0;
        fresh   <= (state_nxt == RUN);
      end
    end
  end

endmodule

// File: tb/tb_tmds_soft_serializer.sv
// Bench for tmds_soft_serializer: a queue-based behavioural model checked every cycle,
// directed scenarios with literal expectations, randomized traffic, and an MSB-first instance.
module tb_tmds_soft_serializer;
  import tmds_pkg::*;

  localparam int CH = 4;
  localparam int W  = 10;
  localparam int D  = 4;
  localparam int CW = CH * W;
  localparam logic [CW-1:0] IDLE = {10'b0000011111, 10'b1101010100, 10'b1101010100, 10'b1101010100};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance (defaults)
  logic          enable, in_valid, in_ready, word_strobe, running;
  logic [CW-1:0] in_data;
  logic [CH-1:0] ser_out;
  logic [2:0]    fifo_level;
  logic [15:0]   underflow_cnt;
  ser_state_t    state_dbg;

  tmds_soft_serializer dut (
    .clk_serial    (clk),
    .rst           (rst),
    .enable        (enable),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .ser_out       (ser_out),
    .word_strobe   (word_strobe),
    .fifo_level    (fifo_level),
    .underflow_cnt (underflow_cnt),
    .running       (running),
    .state_dbg     (state_dbg)
  );

  // MSB-first single-lane instance with a narrow underflow counter
  logic       b_enable, b_valid, b_ready, b_strobe, b_running;
  logic [7:0] b_data;
  logic [0:0] b_ser;
  logic [2:0] b_level;
  logic [7:0] b_cnt;
  ser_state_t b_state;

  tmds_soft_serializer #(
    .CHANNELS  (1),
    .WIDTH     (8),
    .DEPTH     (4),
    .LSB_FIRST (1'b0),
    .IDLE_WORD (8'h3C),
    .UFLOW_W   (8)
  ) dut_b (
    .clk_serial    (clk),
    .rst           (rst),
    .enable        (b_enable),
    .in_valid      (b_valid),
    .in_ready      (b_ready),
    .in_data       (b_data),
    .ser_out       (b_ser),
    .word_strobe   (b_strobe),
    .fifo_level    (b_level),
    .underflow_cnt (b_cnt),
    .running       (b_running),
    .state_dbg     (b_state)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: queued words and the per-cycle bit stream still owed to the line
  logic [CW-1:0] exp_q[$];
  logic [CH-1:0] bit_q[$];
  logic [CH-1:0] m_ser;
  logic          m_strobe;
  logic          m_running;
  int            m_cnt;
  logic          p_push;
  logic [CW-1:0] p_data;

  task automatic model_load();
    logic [CW-1:0] w;
    logic [CH-1:0] v;
    if (exp_q.size() > 0) w = exp_q.pop_front();
    else begin
      w = IDLE;
      if (m_cnt < 65535) m_cnt++;
    end
    for (int i = 0; i < W; i++) begin
      for (int k = 0; k < CH; k++) v[k] = w[k*W + i];
      bit_q.push_back(v);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
        bit_q.delete();
        m_ser     = '0;
        m_strobe  = 1'b0;
        m_running = 1'b0;
        m_cnt     = 0;
      end else begin
        p_push   = in_valid && (exp_q.size() < D);
        p_data   = in_data;
        m_strobe = 1'b0;
        if (!m_running) begin
          m_ser = '0;
          if (enable) m_running = 1'b1;
        end else if (bit_q.size() == 0) begin
          if (enable) begin
            model_load();
            m_strobe = 1'b1;
            m_ser    = bit_q.pop_front();
          end else begin
            m_running = 1'b0;
            m_ser     = '0;
          end
        end else begin
          m_ser = bit_q.pop_front();
        end
        if (p_push) exp_q.push_back(p_data);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        check("ser_out", 32'(ser_out), 32'(m_ser));
        check("word_strobe", 32'(word_strobe), 32'(m_strobe));
        check("running", 32'(running), 32'(m_running));
        check("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
        check("in_ready", 32'(in_ready), 32'(exp_q.size() < D));
        check("underflow_cnt", 32'(underflow_cnt), 32'(m_cnt));
      end
    end
  end

  // driver tasks (all entered and left on a negedge)
  function automatic logic [CW-1:0] rand_word();
    return CW'({$urandom(), $urandom()});
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_word(input logic [CW-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_strobe(input string name, input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (word_strobe) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_stop(input string name, input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!running) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] lane3, lane0;
    logic [7:0] bv;
    int lmin, lmax, n, nb;
    bit got;

    enable = 1'b0; in_valid = 1'b0; in_data = '0;
    b_enable = 1'b0; b_valid = 1'b0; b_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ser_out", 32'(ser_out), 32'd0);
    check("rst_word_strobe", 32'(word_strobe), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_underflow", 32'(underflow_cnt), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    chk_en = 1'b1;

    // starvation: idle symbols on every lane
    enable = 1'b1;
    wait_strobe("t1_first_load", 4);
    lane3[0] = ser_out[3];
    lane0[0] = ser_out[0];
    for (int i = 1; i < W; i++) begin
      @(negedge clk);
      lane3[i] = ser_out[3];
      lane0[i] = ser_out[0];
    end
    check("t1_idle_lane3", 32'(lane3), 32'(10'b0000011111));
    check("t1_idle_lane0", 32'(lane0), 32'(10'b1101010100));
    for (int s = 0; s < 5; s++) wait_strobe("t1_strobe", 11);
    check("t1_underflow_6", 32'(underflow_cnt), 32'd6);
    enable = 1'b0;
    wait_stop("t1_stop", 12);

    // pre-filled FIFO drains in order, fifth load is idle
    do_reset();
    for (int i = 0; i < 4; i++) push_word(rand_word());
    check("t2_ready_full", 32'(in_ready), 32'd0);
    check("t2_level_4", 32'(fifo_level), 32'd4);
    enable = 1'b1;
    for (int s = 0; s < 5; s++) wait_strobe("t2_strobe", 12);
    check("t2_underflow_1", 32'(underflow_cnt), 32'd1);
    enable = 1'b0;
    wait_stop("t2_stop", 12);

    // paced upstream: one push per strobe keeps the FIFO from starving
    do_reset();
    push_word(rand_word());
    push_word(rand_word());
    enable = 1'b1;
    lmin = 99; lmax = 0;
    for (int s = 0; s < 1000; s++) begin
      wait_strobe("t3_strobe", 12);
      if (fifo_level < lmin) lmin = fifo_level;
      push_word(rand_word());
      if (fifo_level > lmax) lmax = fifo_level;
    end
    check("t3_underflow_0", 32'(underflow_cnt), 32'd0);
    check("t3_level_min_ge1", 32'(lmin >= 1), 32'd1);
    check("t3_level_max_le3", 32'(lmax <= 3), 32'd1);
    enable = 1'b0;
    wait_stop("t3_stop", 12);

    // enable dropped during bit 3: symbol completes, head not popped
    do_reset();
    for (int i = 0; i < 3; i++) push_word(rand_word());
    enable = 1'b1;
    wait_strobe("t4_first_load", 4);
    check("t4_level_after_load", 32'(fifo_level), 32'd2);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n++;
      if (!running) begin
        got = 1'b1;
        break;
      end
    end
    check("t4_stopped", 32'(got), 32'd1);
    check("t4_stop_cycles", 32'(n), 32'd7);
    check("t4_level_kept", 32'(fifo_level), 32'd2);
    check("t4_ser_low", 32'(ser_out), 32'd0);

    // reset mid-symbol with 3 words queued
    do_reset();
    for (int i = 0; i < 4; i++) push_word(rand_word());
    enable = 1'b1;
    wait_strobe("t5_first_load", 4);
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_ser_out", 32'(ser_out), 32'd0);
    check("t5_rst_strobe", 32'(word_strobe), 32'd0);
    check("t5_rst_running", 32'(running), 32'd0);
    check("t5_rst_level", 32'(fifo_level), 32'd0);
    check("t5_rst_underflow", 32'(underflow_cnt), 32'd0);
    check("t5_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    wait_strobe("t5_reload", 4);
    check("t5_first_idle", 32'(underflow_cnt), 32'd1);
    enable = 1'b0;
    wait_stop("t5_stop", 12);

    // randomized traffic with enable toggling
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = rand_word();
      @(negedge clk);
    end
    in_valid = 1'b0;
    enable   = 1'b0;
    wait_stop("t6_stop", 12);

    // MSB-first single lane, then counter saturation
    b_valid = 1'b1;
    b_data  = 8'hA5;
    @(negedge clk);
    b_valid  = 1'b0;
    b_enable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b_strobe) begin
        got = 1'b1;
        break;
      end
    end
    check("b_first_load", 32'(got), 32'd1);
    bv = '0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      bv = {bv[6:0], b_ser[0]};
    end
    check("b_msb_first_a5", 32'(bv), 32'h0000_00A5);
    nb = 1;
    for (int c = 0; c < 3000 && nb < 300; c++) begin
      @(negedge clk);
      if (b_strobe) begin
        nb++;
        if (nb == 11) check("b_underflow_10", 32'(b_cnt), 32'd10);
      end
    end
    check("b_strobe_count", 32'(nb), 32'd300);
    check("b_underflow_sat", 32'(b_cnt), 32'h0000_00FF);
    repeat (20) @(negedge clk);
    check("b_underflow_hold", 32'(b_cnt), 32'h0000_00FF);
    b_enable = 1'b0;

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
